fetch_unit: RTL and testbench

Parametrised successor of the PC/stack/IF_ID portion of the pipelined datapath. Owns the program counter, next-PC selection (sequential, relative branch, absolute jump, return), a bounded return-address stack with overflow/underflow detection, and the IF/ID pipeline register with stall, flush and valid bit. Sits between the combinational instruction memory and the ID-stage controller/decoder.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/return_addr_stack.sv | 97 +++++++++
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared next-PC select encodings and default bubble value
// Revision    : 1.0
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_REL = 2'b01,
        PC_ABS = 2'b10,
        PC_RET = 2'b11
    } pc_sel_e;

    localparam int unsigned DEFAULT_NOP = 0;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/return_addr_stack.sv
`default_nettype none
// ============================================================================
// Module      : return_addr_stack
// Description : Bounded circular return-address stack with sticky error flags
// Revision    : 1.0
// ============================================================================
module return_addr_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 12,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             ret_i,
    input  logic [W-1:0]     push_val_i,
    output logic [W-1:0]     top_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output logic             overflow_o,
    output logic             underflow_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] top_q, top_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             wr_en;
    logic [PTR_W-1:0] wr_ptr;
    logic             empty;
    logic             full;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    always_comb begin
        top_d   = top_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        wr_en   = 1'b0;
        wr_ptr  = top_q + 1'b1;
        if (reset && en_i) begin
            if (empty && (pop_i || ret_i)) begin
                unf_d = 1'b1;
            end
            if (push_i && pop_i && !empty) begin
                // Return consumes the old top; the call's address takes its slot.
                wr_en  = 1'b1;
                wr_ptr = top_q;
            end else if (push_i) begin
                wr_en = 1'b1;
                top_d = top_q + 1'b1;
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else if (pop_i && !empty) begin
                top_d   = top_q - 1'b1;
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            top_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr] <= push_val_i;
        end
    end

    assign top_o       = mem_q[top_q];
    assign empty_o     = empty;
    assign count_o     = count_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

endmodule : return_addr_stack
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : PC, next-PC selection, return-address stack and IF/ID register
// Revision    : 1.0
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned        PC_W      = 12,
    parameter int unsigned        INSTR_W   = 19,
    parameter int unsigned        OFFSET_W  = 8,
    parameter int unsigned        RAS_DEPTH = 8,
    parameter logic [INSTR_W-1:0] NOP       = INSTR_W'(DEFAULT_NOP)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall_i,
    input  logic                       flush_i,
    input  logic [1:0]                 pc_sel_i,
    input  logic [OFFSET_W-1:0]        branch_offset_i,
    input  logic [PC_W-1:0]            jump_target_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    output logic [PC_W-1:0]            imem_addr_o,
    input  logic [INSTR_W-1:0]         imem_data_i,
    output logic [INSTR_W-1:0]         ifid_instr_o,
    output logic [PC_W-1:0]            ifid_pc_o,
    output logic                       ifid_valid_o,
    output logic [$clog2(RAS_DEPTH):0] ras_count_o,
    output logic                       ras_overflow_o,
    output logic                       ras_underflow_o
);
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ifid_instr_q;
    logic [PC_W-1:0]    ifid_pc_q;
    logic               ifid_valid_q;
    logic [PC_W-1:0]    pc_plus1;
    logic [PC_W-1:0]    offset_ext;
    logic [PC_W-1:0]    ras_top;
    logic               ras_empty;
    logic               is_ret;

    assign pc_plus1   = pc_q + 1'b1;
    assign offset_ext = {{(PC_W-OFFSET_W){branch_offset_i[OFFSET_W-1]}}, branch_offset_i};
    assign is_ret     = (pc_sel_e'(pc_sel_i) == PC_RET);

    always_comb begin
        pc_d = pc_plus1;
        unique case (pc_sel_e'(pc_sel_i))
            PC_SEQ: pc_d = pc_plus1;
            PC_REL: pc_d = ifid_pc_q + PC_W'(1) + offset_ext;
            PC_ABS: pc_d = jump_target_i;
            PC_RET: pc_d = ras_empty ? pc_plus1 : ras_top;
        endcase
    end

    return_addr_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .clk         (clk),
        .reset       (reset),
        .en_i        (!stall_i),
        .push_i      (push_i),
        .pop_i       (pop_i),
        .ret_i       (is_ret),
        .push_val_i  (pc_plus1),
        .top_o       (ras_top),
        .empty_o     (ras_empty),
        .count_o     (ras_count_o),
        .overflow_o  (ras_overflow_o),
        .underflow_o (ras_underflow_o)
    );

    // Flush wins over stall for IF/ID only; the PC still honours stall.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q         <= '0;
            ifid_instr_q <= NOP;
            ifid_pc_q    <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            if (!stall_i) begin
                pc_q <= pc_d;
            end
            if (flush_i) begin
                ifid_instr_q <= NOP;
                ifid_pc_q    <= pc_q;
                ifid_valid_q <= 1'b0;
            end else if (!stall_i) begin
                ifid_instr_q <= imem_data_i;
                ifid_pc_q    <= pc_q;
                ifid_valid_q <= 1'b1;
            end
        end
    end

    assign imem_addr_o  = pc_q;
    assign ifid_instr_o = ifid_instr_q;
    assign ifid_pc_o    = ifid_pc_q;
    assign ifid_valid_o = ifid_valid_q;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed plus random checks of fetch_unit against a queue model
// Revision    : 1.0
// ============================================================================
module tb_fetch_unit;
    localparam int PC_W      = 12;
    localparam int INSTR_W   = 19;
    localparam int OFFSET_W  = 8;
    localparam int RAS_DEPTH = 8;
    localparam logic [INSTR_W-1:0] NOP_V = '0;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 stall_i = 1'b0;
    logic                 flush_i = 1'b0;
    logic [1:0]           pc_sel_i = 2'b00;
    logic [OFFSET_W-1:0]  branch_offset_i = '0;
    logic [PC_W-1:0]      jump_target_i = '0;
    logic                 push_i = 1'b0;
    logic                 pop_i = 1'b0;
    logic [INSTR_W-1:0]   imem_data_i = '0;
    logic [PC_W-1:0]      imem_addr_o;
    logic [INSTR_W-1:0]   ifid_instr_o;
    logic [PC_W-1:0]      ifid_pc_o;
    logic                 ifid_valid_o;
    logic [3:0]           ras_count_o;
    logic                 ras_overflow_o;
    logic                 ras_underflow_o;

    fetch_unit #(
        .PC_W      (PC_W),
        .INSTR_W   (INSTR_W),
        .OFFSET_W  (OFFSET_W),
        .RAS_DEPTH (RAS_DEPTH),
        .NOP       (NOP_V)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .pc_sel_i        (pc_sel_i),
        .branch_offset_i (branch_offset_i),
        .jump_target_i   (jump_target_i),
        .push_i          (push_i),
        .pop_i           (pop_i),
        .imem_addr_o     (imem_addr_o),
        .imem_data_i     (imem_data_i),
        .ifid_instr_o    (ifid_instr_o),
        .ifid_pc_o       (ifid_pc_o),
        .ifid_valid_o    (ifid_valid_o),
        .ras_count_o     (ras_count_o),
        .ras_overflow_o  (ras_overflow_o),
        .ras_underflow_o (ras_underflow_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference state: the stack is a bounded queue, newest entry at the back.
    logic [PC_W-1:0]    m_pc = '0;
    logic [PC_W-1:0]    m_ifid_pc = '0;
    logic [INSTR_W-1:0] m_instr = '0;
    logic               m_valid = 1'b0;
    logic               m_ovf = 1'b0;
    logic               m_unf = 1'b0;
    logic [PC_W-1:0]    m_ras[$];

    function automatic logic [INSTR_W-1:0] instr_of(input logic [PC_W-1:0] a);
        return {7'h2B, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all();
        chk("pc", 32'(imem_addr_o), 32'(m_pc));
        chk("ifid_instr", 32'(ifid_instr_o), 32'(m_instr));
        chk("ifid_pc", 32'(ifid_pc_o), 32'(m_ifid_pc));
        chk("ifid_valid", 32'(ifid_valid_o), 32'(m_valid));
        chk("ras_count", 32'(ras_count_o), 32'(m_ras.size()));
        chk("ras_overflow", 32'(ras_overflow_o), 32'(m_ovf));
        chk("ras_underflow", 32'(ras_underflow_o), 32'(m_unf));
    endtask

    task automatic step(input logic rst_n, input logic st, input logic fl, input logic [1:0] sel,
                        input logic [OFFSET_W-1:0] off, input logic [PC_W-1:0] tgt,
                        input logic ps, input logic pp);
        logic [PC_W-1:0] n_pc;
        int              soff;
        reset           = rst_n;
        stall_i         = st;
        flush_i         = fl;
        pc_sel_i        = sel;
        branch_offset_i = off;
        jump_target_i   = tgt;
        push_i          = ps;
        pop_i           = pp;
        imem_data_i     = instr_of(m_pc);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_pc = '0; m_ifid_pc = '0; m_instr = NOP_V; m_valid = 1'b0;
            m_ovf = 1'b0; m_unf = 1'b0; m_ras.delete();
        end else begin
            n_pc = m_pc;
            if (!st) begin
                soff = int'($signed(off));
                case (sel)
                    2'd0: n_pc = m_pc + 1;
                    2'd1: n_pc = PC_W'(int'(m_ifid_pc) + 1 + soff);
                    2'd2: n_pc = tgt;
                    default: n_pc = (m_ras.size() > 0) ? m_ras[$] : PC_W'(m_pc + 1);
                endcase
                if (m_ras.size() == 0 && (pp || sel == 2'd3)) m_unf = 1'b1;
                if (ps && pp && m_ras.size() > 0) begin
                    m_ras[m_ras.size()-1] = m_pc + 1;
                end else if (ps) begin
                    m_ras.push_back(m_pc + 1);
                    if (m_ras.size() > RAS_DEPTH) begin
                        void'(m_ras.pop_front());
                        m_ovf = 1'b1;
                    end
                end else if (pp && m_ras.size() > 0) begin
                    void'(m_ras.pop_back());
                end
            end
            if (fl) begin
                m_instr = NOP_V; m_valid = 1'b0; m_ifid_pc = m_pc;
            end else if (!st) begin
                m_instr = instr_of(m_pc); m_valid = 1'b1; m_ifid_pc = m_pc;
            end
            m_pc = n_pc;
        end
        check_all();
    endtask

    task automatic run(input logic [1:0] sel, input logic [PC_W-1:0] tgt,
                       input logic ps, input logic pp);
        step(1'b1, 1'b0, 1'b0, sel, 8'h00, tgt, ps, pp);
    endtask

    logic [PC_W-1:0] held_pc;

    initial begin
        // Reset and sequential fetch
        step(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 12'h000, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 2'd2, 8'h00, 12'h555, 1'b1, 1'b1);
        chk("reset_pc", 32'(imem_addr_o), 32'h0);
        chk("reset_valid", 32'(ifid_valid_o), 32'h0);
        for (int i = 0; i < 4; i++) begin
            run(2'd0, 12'h000, 1'b0, 1'b0);
            chk("seq_pc", 32'(imem_addr_o), 32'(i + 1));
        end

        // Relative branch backwards and PC wrap
        run(2'd2, 12'h010, 1'b0, 1'b0);
        run(2'd0, 12'h000, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 2'd1, 8'hFC, 12'h000, 1'b0, 1'b0);
        chk("rel_target", 32'(imem_addr_o), 32'h00D);
        run(2'd2, 12'hFFF, 1'b0, 1'b0);
        run(2'd0, 12'h000, 1'b0, 1'b0);
        chk("pc_wrap", 32'(imem_addr_o), 32'h000);

        // Call and return
        run(2'd2, 12'h020, 1'b0, 1'b0);
        run(2'd2, 12'h100, 1'b1, 1'b0);
        chk("call_target", 32'(imem_addr_o), 32'h100);
        run(2'd0, 12'h000, 1'b0, 1'b0);
        run(2'd0, 12'h000, 1'b0, 1'b0);
        run(2'd3, 12'h000, 1'b0, 1'b1);
        chk("return_pc", 32'(imem_addr_o), 32'h021);
        chk("return_count", 32'(ras_count_o), 32'h0);

        // Stall ignores redirect; flush under stall bubbles IF/ID only
        held_pc = m_pc;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 2'd2, 8'h00, 12'h3AA, 1'b1, 1'b0);
        chk("stall_pc", 32'(imem_addr_o), 32'(held_pc));
        step(1'b1, 1'b1, 1'b1, 2'd2, 8'h00, 12'h3AA, 1'b0, 1'b0);
        chk("stall_flush_instr", 32'(ifid_instr_o), 32'(NOP_V));
        chk("stall_flush_pc", 32'(imem_addr_o), 32'(held_pc));

        // Overflow then drain into underflow
        run(2'd2, 12'h000, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) run(2'd0, 12'h000, 1'b1, 1'b0);
        chk("ovf_flag", 32'(ras_overflow_o), 32'h1);
        chk("ovf_count", 32'(ras_count_o), 32'h8);
        for (int i = 0; i < 8; i++) begin
            run(2'd3, 12'h000, 1'b0, 1'b1);
            chk("pop_value", 32'(imem_addr_o), 32'(9 - i));
        end
        run(2'd3, 12'h000, 1'b0, 1'b1);
        chk("unf_flag", 32'(ras_underflow_o), 32'h1);
        chk("unf_pc", 32'(imem_addr_o), 32'h003);

        // Push+pop on a full stack
        step(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 12'h000, 1'b0, 1'b0);
        run(2'd2, 12'h048, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) run(2'd0, 12'h000, 1'b1, 1'b0);
        run(2'd2, 12'h070, 1'b0, 1'b0);
        run(2'd3, 12'h000, 1'b1, 1'b1);
        chk("pp_pc", 32'(imem_addr_o), 32'h050);
        chk("pp_count", 32'(ras_count_o), 32'h8);
        chk("pp_no_ovf", 32'(ras_overflow_o), 32'h0);
        run(2'd3, 12'h000, 1'b0, 1'b1);
        chk("pp_new_top", 32'(imem_addr_o), 32'h071);

        // Random traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 39) != 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
                 OFFSET_W'($urandom), PC_W'($urandom),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire
